// File: rtl/alu_issue.sv
// Execute-stage ALU issuer: decode into S1, drive the alu, register the result.
// Optional statistics counters are built when ALU_ISSUE_STATS_EN is defined.
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_SLL 4'd2
`define ALU_LT  4'd3
`define ALU_LTU 4'd4
`define ALU_XOR 4'd5
`define ALU_SRL 4'd6
`define ALU_SRA 4'd7
`define ALU_OR  4'd8
`define ALU_AND 4'd9
`endif

module alu_issue #(
    parameter int RD_BITS     = 4,
    parameter int STATS_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_opcode,
    input  logic [2:0]             in_funct3,
    input  logic                   in_funct7_5,
    input  logic [31:0]            in_rs1_data,
    input  logic [31:0]            in_rs2_data,
    input  logic [31:0]            in_imm,
    input  logic [31:0]            in_pc,
    input  logic [RD_BITS-1:0]     in_rd,
    output logic [3:0]             alu_operation,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    input  logic [31:0]            alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RD_BITS-1:0]     out_rd,
    output logic [31:0]            out_data,
    output logic                   out_we,
    output logic                   out_illegal,
    output logic [STATS_WIDTH-1:0] stat_retired,
    output logic [STATS_WIDTH-1:0] stat_stalls
);

    logic               s1_valid;
    logic [RD_BITS-1:0] s1_rd;
    logic               s1_we;
    logic               s1_illegal;

    logic       adv_out, s1_adv, accept;
    logic       is_op, is_opi, is_lui, is_auipc;
    logic [3:0] f3_op;
    logic [3:0] d_op;
    logic [31:0] d_a, d_b;
    logic       d_ill;

    assign adv_out  = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv_out;
    assign s1_adv   = s1_valid && adv_out;
    assign accept   = in_valid && in_ready;

    assign is_op    = in_opcode == 7'b0110011;
    assign is_opi   = in_opcode == 7'b0010011;
    assign is_lui   = in_opcode == 7'b0110111;
    assign is_auipc = in_opcode == 7'b0010111;

    always_comb begin
        f3_op = `ALU_ADD;
        unique case (in_funct3)
            3'b000: f3_op = (is_op && in_funct7_5) ? `ALU_SUB : `ALU_ADD;
            3'b001: f3_op = `ALU_SLL;
            3'b010: f3_op = `ALU_LT;
            3'b011: f3_op = `ALU_LTU;
            3'b100: f3_op = `ALU_XOR;
            3'b101: f3_op = in_funct7_5 ? `ALU_SRA : `ALU_SRL;
            3'b110: f3_op = `ALU_OR;
            3'b111: f3_op = `ALU_AND;
        endcase
    end

    always_comb begin
        d_op  = `ALU_ADD;
        d_a   = '0;
        d_b   = '0;
        d_ill = 1'b0;
        unique case (1'b1)
            is_op: begin
                d_op = f3_op;
                d_a  = in_rs1_data;
                d_b  = in_rs2_data;
            end
            is_opi: begin
                if (in_funct3 == 3'b001 && in_funct7_5) begin
                    d_ill = 1'b1;
                end else begin
                    d_op = f3_op;
                    d_a  = in_rs1_data;
                    // shift immediates only carry a 5-bit shamt
                    if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                        d_b = {27'b0, in_imm[4:0]};
                    else
                        d_b = in_imm;
                end
            end
            is_lui: d_b = in_imm;
            is_auipc: begin
                d_a = in_pc;
                d_b = in_imm;
            end
            default: d_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            alu_operation <= `ALU_ADD;
            alu_a         <= '0;
            alu_b         <= '0;
            s1_rd         <= '0;
            s1_we         <= 1'b0;
            s1_illegal    <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid      <= 1'b1;
                alu_operation <= d_op;
                alu_a         <= d_a;
                alu_b         <= d_b;
                s1_rd         <= in_rd;
                s1_we         <= (in_rd != '0) && !d_ill;
                s1_illegal    <= d_ill;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_rd      <= '0;
            out_data    <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (adv_out)
                out_valid <= s1_valid;
            if (s1_adv) begin
                out_rd      <= s1_rd;
                out_data    <= s1_illegal ? '0 : alu_result;
                out_we      <= s1_we;
                out_illegal <= s1_illegal;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_retired <= '0;
            stat_stalls  <= '0;
        end else begin
            if (out_valid && out_ready)
                stat_retired <= stat_retired + STATS_WIDTH'(1);
            if (out_valid && !out_ready)
                stat_stalls <= stat_stalls + STATS_WIDTH'(1);
        end
    end
`else
    assign stat_retired = '0;
    assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: semantic reference model, bench-side alu,
// random and directed stimulus, stall/throughput and mid-flight reset.
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_SLL 4'd2
`define ALU_LT  4'd3
`define ALU_LTU 4'd4
`define ALU_XOR 4'd5
`define ALU_SRL 4'd6
`define ALU_SRA 4'd7
`define ALU_OR  4'd8
`define ALU_AND 4'd9
`endif

module tb_alu_issue;
    localparam int RB = 4;
    localparam int SW = 32;
    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;

    logic          clk = 0;
    logic          rst = 1;
    logic          in_valid = 0;
    logic          in_ready;
    logic [6:0]    in_opcode = 0;
    logic [2:0]    in_funct3 = 0;
    logic          in_funct7_5 = 0;
    logic [31:0]   in_rs1_data = 0, in_rs2_data = 0, in_imm = 0, in_pc = 0;
    logic [RB-1:0] in_rd = 0;
    logic [3:0]    alu_operation;
    logic [31:0]   alu_a, alu_b, alu_result;
    logic          out_valid;
    logic          out_ready = 0;
    logic [RB-1:0] out_rd;
    logic [31:0]   out_data;
    logic          out_we, out_illegal;
    logic [SW-1:0] stat_retired, stat_stalls;

    alu_issue #(.RD_BITS(RB), .STATS_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_funct7_5(in_funct7_5),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
        .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data),
        .out_we(out_we), .out_illegal(out_illegal),
        .stat_retired(stat_retired), .stat_stalls(stat_stalls)
    );

    always #5 clk = ~clk;

    // the combinational alu on the far side of the interface
    always_comb begin
        alu_result = 32'h0;
        case (alu_operation)
            `ALU_ADD: alu_result = alu_a + alu_b;
            `ALU_SUB: alu_result = alu_a - alu_b;
            `ALU_SLL: alu_result = alu_a << alu_b[4:0];
            `ALU_LT:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            `ALU_LTU: alu_result = {31'b0, alu_a < alu_b};
            `ALU_XOR: alu_result = alu_a ^ alu_b;
            `ALU_SRL: alu_result = alu_a >> alu_b[4:0];
            `ALU_SRA: alu_result = $signed(alu_a) >>> alu_b[4:0];
            `ALU_OR:  alu_result = alu_a | alu_b;
            `ALU_AND: alu_result = alu_a & alu_b;
            default:  alu_result = 32'h0;
        endcase
    end

    typedef struct packed {
        logic [RB-1:0] rd;
        logic [31:0]   data;
        logic          we;
        logic          ill;
    } rec_t;

    rec_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   inflight = 0;
    logic rnd_on = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // instruction semantics of RV32E integer ops
    function automatic rec_t ref_model(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic f7, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic [31:0] imm,
                                       input logic [31:0] pc, input logic [RB-1:0] rd);
        rec_t r;
        logic [31:0] v;
        logic [31:0] y;
        logic ill;
        v = 0;
        ill = 0;
        y = (opc == OP) ? rs2 : imm;
        if (opc == OP || opc == OPI) begin
            case (f3)
                3'd0: v = (opc == OP && f7) ? rs1 - y : rs1 + y;
                3'd1: begin
                    if (opc == OPI && f7) ill = 1;
                    v = rs1 << y[4:0];
                end
                3'd2: v = ($signed(rs1) < $signed(y)) ? 32'd1 : 32'd0;
                3'd3: v = (rs1 < y) ? 32'd1 : 32'd0;
                3'd4: v = rs1 ^ y;
                3'd5: v = f7 ? 32'($signed(rs1) >>> y[4:0]) : rs1 >> y[4:0];
                3'd6: v = rs1 | y;
                default: v = rs1 & y;
            endcase
        end else if (opc == LUI) begin
            v = imm;
        end else if (opc == AUI) begin
            v = pc + imm;
        end else begin
            ill = 1;
        end
        if (ill) v = 0;
        r.rd   = rd;
        r.data = v;
        r.we   = (rd != 0) && !ill;
        r.ill  = ill;
        return r;
    endfunction

    // called right after a rising edge; returns one edge after acceptance
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [RB-1:0] rd);
        int n;
        n = 0;
        in_valid = 1;
        in_opcode = opc;
        in_funct3 = f3;
        in_funct7_5 = f7;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        in_imm = imm;
        in_pc = pc;
        in_rd = rd;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 0, 1);
            @(posedge clk);
            #1 in_valid = 0;
            return;
        end
        sbq.push_back(ref_model(opc, f3, f7, rs1, rs2, imm, pc, rd));
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    rec_t prev;
    logic prev_hold = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev.data);
                chk("hold_rd", out_rd, prev.rd);
                chk("hold_we", out_we, prev.we);
            end
            chk("in_ready", in_ready, !(inflight == 2 && !out_ready));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_record", 1, 0);
                end else begin
                    rec_t e;
                    e = sbq.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_rd", out_rd, e.rd);
                    chk("out_we", out_we, e.we);
                    chk("out_illegal", out_illegal, e.ill);
                end
            end
            inflight += int'(in_valid && in_ready) - int'(out_valid && out_ready);
            prev_hold = out_valid && !out_ready;
            prev.data = out_data;
            prev.rd = out_rd;
            prev.we = out_we;
            prev.ill = out_illegal;
        end
    end

    always @(posedge clk) begin
        if (rnd_on) #1 out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [SW-1:0] r0, s0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_op", alu_operation, `ALU_ADD);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_flags", {out_rd, out_we, out_illegal}, 0);
        chk("rst_stat_retired", stat_retired, 0);
        chk("rst_stat_stalls", stat_stalls, 0);
        @(posedge clk);
        #1 rst = 0;
        out_ready = 1;

        issue(OP, 3'd0, 0, 32'd100, -32'sd100, 0, 0, 4'd5);
        @(negedge clk);
        chk("add_op", alu_operation, `ALU_ADD);
        @(negedge clk);
        chk("add_valid", out_valid, 1);
        chk("add_data", out_data, 0);
        chk("add_we_rd", {out_we, out_rd}, {1'b1, 4'd5});
        @(posedge clk);
        #1;
        issue(OP, 3'd0, 1, -32'sd100, 32'd100, 0, 0, 4'd3);
        @(negedge clk);
        chk("sub_op", alu_operation, `ALU_SUB);
        @(negedge clk);
        chk("sub_data", out_data, -32'sd200);
        @(posedge clk);
        #1;
        issue(OPI, 3'd5, 1, -32'sd100, 0, 32'h401, 0, 4'd2);
        @(negedge clk);
        chk("srai_op", alu_operation, `ALU_SRA);
        chk("srai_b", alu_b, 1);
        @(negedge clk);
        chk("srai_data", out_data, -32'sd50);
        @(posedge clk);
        #1;
        issue(OPI, 3'd5, 0, 32'hffff_ffff, 0, 32'd31, 0, 4'd2);
        issue(LUI, 3'd0, 0, 32'h5555, 0, 32'h1234_5000, 0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("lui_data", out_data, 32'h1234_5000);
        chk("lui_we", out_we, 0);
        @(posedge clk);
        #1;
        issue(AUI, 3'd0, 0, 0, 0, 32'h1000, 32'h100, 4'd1);
        issue(7'b0000011, 3'd2, 0, 32'd7, 32'd9, 32'd4, 0, 4'd7);
        @(negedge clk);
        chk("ill_alu", {alu_operation, alu_a, alu_b}, {`ALU_ADD, 64'h0});
        @(negedge clk);
        chk("ill_flags", {out_illegal, out_we}, 2'b10);
        @(posedge clk);
        #1;
        issue(OPI, 3'd1, 1, 32'd3, 0, 32'd2, 0, 4'd4);
        drain();

        // stall and throughput
        out_ready = 0;
        r0 = stat_retired;
        s0 = stat_stalls;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    issue(OP, 3'd0, 0, 32'(i * 10), 32'd1, 0, 0, 4'(i + 1));
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("burst_valid", out_valid, 1);
                end
            end
        join
        @(posedge clk);
        #1;
        drain();
`ifdef ALU_ISSUE_STATS_EN
        chk("stat_retired", stat_retired - r0, 4);
        chk("stat_stalls", stat_stalls - s0, 3);
`else
        chk("stat_retired_off", stat_retired, 0);
        chk("stat_stalls_off", stat_stalls, 0);
`endif

        // randomized traffic with random backpressure
        rnd_on = 1;
        for (int i = 0; i < 300; i++) begin
            logic [6:0] opc;
            logic [31:0] a, b;
            int k;
            k = $urandom_range(0, 9);
            opc = (k < 4) ? OP : (k < 7) ? OPI : (k == 7) ? LUI :
                  (k == 8) ? AUI : 7'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            issue(opc, 3'($urandom), 1'($urandom), a, b, $urandom, $urandom,
                  4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_on = 0;
        @(posedge clk);
        #2 out_ready = 1;
        drain();

        // reset with both stages occupied
        out_ready = 0;
        issue(OP, 3'd4, 0, 32'h0f0f, 32'hff00, 0, 0, 4'd9);
        issue(OP, 3'd6, 0, 32'h0f0f, 32'hff00, 0, 0, 4'd10);
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #1 rst = 1;
        sbq.delete();
        inflight = 0;
        @(posedge clk);
        #1 rst = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Execute-stage issuer for the RV32E core: the requesting end of the ALU interface.
- Accepts decoded integer instructions (OP, OP-IMM, LUI, AUIPC) over a valid/ready handshake.
- Maps opcode/funct fields to the 4-bit ALU operation codes from defines.vh and selects the operands.
- Drives the combinational alu, captures its result, and presents a writeback record downstream.
- Two-stage pipeline, full throughput, backpressure-aware.

Parameters:
RD_BITS, 4, destination register index width (RV32E, 16 regs)
STATS_WIDTH, 32, width of statistics counters (optional feature)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  reset
in_valid  input  1  instruction offered
in_ready  output  1  instruction accepted when in_valid && in_ready
in_opcode  input  7  instr[6:0]
in_funct3  input  3  instr[14:12]
in_funct7_5  input  1  instr[30]
in_rs1_data  input  32  rs1 value
in_rs2_data  input  32  rs2 value
in_imm  input  32  sign-extended immediate (I or U form per opcode)
in_pc  input  32  instruction PC
in_rd  input  RD_BITS  destination register
alu_operation  output  4  to alu operation
alu_a  output  32  to alu operand a
alu_b  output  32  to alu operand b
alu_result  input  32  from alu (combinational)
out_valid  output  1  writeback record valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_rd  output  RD_BITS  destination
out_data  output  32  result
out_we  output  1  register write enable
out_illegal  output  1  unsupported encoding
stat_retired  output  STATS_WIDTH  records accepted downstream
stat_stalls  output  STATS_WIDTH  cycles with out_valid && !out_ready

Behaviour:
Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.

Reset values:
- s1_valid, out_valid = 0; alu_operation = `ALU_ADD.
- alu_a, alu_b, out_data, out_rd, out_we, out_illegal = 0.
- Stat counters = 0.
- Reset mid-operation discards both stages; nothing is emitted afterwards.

Pipeline:
- S1 register holds decoded op, a, b, rd, we, illegal. alu_* ports are driven directly from S1.
- Output register captures alu_result.
- Accept at edge N → S1 loaded at N → out_valid at edge N+1.
- alu_* outputs are stable whenever s1_valid.

Handshake:
- adv_out = !out_valid || out_ready.
- in_ready = !s1_valid || adv_out. Combinational; independent of in_valid.
- S1 moves to the output register when s1_valid && adv_out.
- When S1 moves out and a new instruction is accepted in the same edge, both happen (back-to-back, 1 per cycle).
- out_valid && !out_ready: output register and S1 hold; alu_* stable.
- Output fields never change while out_valid && !out_ready.

Decode, by opcode:
- OP 0110011: a = rs1, b = rs2.
- OP-IMM 0010011: a = rs1, b = imm. For funct3 001/101, b = {27'b0, imm[4:0]}.
- LUI 0110111: a = 0, b = imm, `ALU_ADD.
- AUIPC 0010111: a = pc, b = imm, `ALU_ADD.

Decode, funct3 → operation:
- 000: ADD; SUB only for OP with funct7_5 = 1. OP-IMM is always ADD.
- 001: SLL. 010: LT. 011: LTU. 100: XOR.
- 101: SRL, or SRA if funct7_5 = 1.
- 110: OR. 111: AND.

Illegal cases:
- Any other opcode.
- OP-IMM funct3 = 001 with funct7_5 = 1.
- Either case gives: illegal = 1, we = 0, operation `ALU_ADD, a = b = 0, out_data = 0.

Write enable and data:
- we = (rd != 0) && !illegal.
- out_data = alu_result even when rd = 0 (illegal case: 0).
- Arithmetic is 32-bit wrap-around; LT/LTU results are 0 or 1 (from alu).

Optional Feature:
Macro ALU_ISSUE_STATS_EN.
- Defined:
  - stat_retired increments on each out_valid && out_ready edge.
  - stat_stalls increments each cycle out_valid && !out_ready.
  - Both wrap modulo 2^STATS_WIDTH.
  - Both cleared by rst.
- Not defined: both outputs tied to 0 and no counter flops are built.

Test Plan:
- OP ADD, rs1 = 100, rs2 = -100, rd = 5, out_ready = 1 → one cycle after accept: out_data = 0, out_we = 1, out_rd = 5.
- OP funct3 = 000, funct7_5 = 1, rs1 = -100, rs2 = 100 → alu_operation = `ALU_SUB; out_data = -200.
- OP-IMM SRAI: rs1 = -100, imm = 0x401 (funct7_5 = 1) → alu_b = 1, `ALU_SRA, out_data = -50. SRLI rs1 = -1, imm = 31 → out_data = 1.
- LUI imm = 0x12345000, rd = 0 → out_data = 0x12345000, out_we = 0. AUIPC pc = 0x100, imm = 0x1000 → out_data = 0x1100.
- Opcode 0000011 → out_illegal = 1, out_we = 0, out_data = 0.
- Stall and throughput, with STATS_EN defined:
  - Stream 4 instructions with out_ready low 3 cycles after the first: out_data held stable; in_ready = 0 once S1 is full.
  - Release out_ready: 4 records in order, one per cycle.
  - stat_retired = 4, stat_stalls = 3.
- Assert rst while both stages are valid → out_valid = 0 next cycle and no record emitted.
